// File: rtl/eth_rx_dispatch8.sv
// Receive-side sequencer for the 8-bit Ethernet header decoder: gates the 14
// header bytes, filters on destination MAC, steers payload by EtherType.
module eth_rx_dispatch8 #(
   parameter int          AVL_SIZE  = 8,
   parameter int          MAC_SIZE  = 48,
   parameter int          HDR_BYTES = 14,
   parameter logic [15:0] TYPE_IPV4 = 16'h0800,
   parameter logic [15:0] TYPE_ARP  = 16'h0806,
   parameter int          CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 sync_reset,
   input  logic [AVL_SIZE-1:0]  data_in,
   input  logic                 data_in_valid,
   input  logic                 data_in_sop,
   input  logic                 data_in_eop,
   input  logic                 data_in_error,
   input  logic [MAC_SIZE-1:0]  local_mac,
   input  logic                 promisc,
   output logic                 dec_data_valid,
   input  logic [MAC_SIZE-1:0]  dec_dest_mac,
   input  logic [15:0]          dec_packet_type,
   output logic [AVL_SIZE-1:0]  payload_data,
   output logic                 ip_valid,
   output logic                 arp_valid,
   output logic                 payload_sop,
   output logic                 payload_eop,
   output logic                 payload_error,
   output logic                 payload_abort,
   output logic [CNT_WIDTH-1:0] frames_accepted,
   output logic [CNT_WIDTH-1:0] frames_dropped
);

   typedef enum logic [2:0] {ST_IDLE, ST_HEADER, ST_ROUTE, ST_PAYLOAD, ST_DROP} state_t;
   typedef enum logic [1:0] {RT_DROP, RT_IP, RT_ARP} route_t;

   localparam logic [3:0]           HDR_LAST = 4'(HDR_BYTES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
   localparam logic [MAC_SIZE-1:0]  MAC_BCAST = '1;

   state_t                r_state;
   state_t                w_state_next;
   route_t                r_route;
   route_t                w_route_comb;
   route_t                w_route_eff;
   logic [3:0]            r_hdr_cnt;
   logic                  r_emitted;
   logic                  w_sop;
   logic                  w_eop;
   logic                  w_mac_match;
   logic                  w_fwd;
   logic                  w_abort;
   logic                  w_inc_acc;
   logic                  w_inc_drop;
   logic                  w_dec_valid;
   logic [AVL_SIZE-1:0]   r_payload_data;
   logic                  r_ip_valid;
   logic                  r_arp_valid;
   logic                  r_payload_sop;
   logic                  r_payload_eop;
   logic                  r_payload_error;
   logic                  r_payload_abort;
   logic [CNT_WIDTH-1:0]  r_frames_accepted;
   logic [CNT_WIDTH-1:0]  r_frames_dropped;

   assign w_sop = data_in_valid & data_in_sop;
   assign w_eop = data_in_valid & data_in_eop;

   assign w_mac_match = promisc | (dec_dest_mac == local_mac) | (dec_dest_mac == MAC_BCAST);

   // Decoder fields are only final in ROUTE; later states use the latched copy.
   always_comb begin
      w_route_comb = RT_DROP;
      if (w_mac_match) begin
         if (dec_packet_type == TYPE_IPV4)     w_route_comb = RT_IP;
         else if (dec_packet_type == TYPE_ARP) w_route_comb = RT_ARP;
      end
   end

   assign w_route_eff = (r_state == ST_ROUTE) ? w_route_comb : r_route;

   // NOTE: state and datapath registers use non-blocking assignments so every
   // always_ff reads the pre-edge value of its neighbours.
   always_ff @(posedge clk) begin
      if (sync_reset) r_state <= ST_IDLE;
      else            r_state <= w_state_next;
   end

   // NOTE: every combinational output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: ;
         ST_HEADER: begin
            if (w_eop)                                     w_state_next = ST_IDLE;
            else if (data_in_valid && r_hdr_cnt == HDR_LAST) w_state_next = ST_ROUTE;
         end
         ST_ROUTE: begin
            if (w_eop)                        w_state_next = ST_IDLE;
            else if (w_route_comb == RT_DROP) w_state_next = ST_DROP;
            else                              w_state_next = ST_PAYLOAD;
         end
         ST_PAYLOAD, ST_DROP: begin
            if (w_eop) w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
      // An SOP always restarts the header, whatever the current state.
      if (w_sop) w_state_next = data_in_eop ? ST_IDLE : ST_HEADER;
   end

   always_comb begin
      w_dec_valid = w_sop | ((r_state == ST_HEADER) & data_in_valid);
      w_fwd       = 1'b0;
      w_abort     = 1'b0;
      w_inc_drop  = 1'b0;
      case (r_state)
         ST_HEADER:  w_inc_drop = w_eop;
         ST_ROUTE: begin
            if (w_route_comb == RT_DROP) w_inc_drop = w_eop;
            else                         w_fwd      = data_in_valid;
         end
         ST_PAYLOAD: w_fwd      = data_in_valid;
         ST_DROP:    w_inc_drop = w_eop;
         default: ;
      endcase
      if (w_sop) begin
         w_fwd      = 1'b0;
         w_inc_drop = (r_state != ST_IDLE) | data_in_eop;
         w_abort    = r_emitted;
      end
      w_inc_acc = w_fwd & data_in_eop;
   end

   assign dec_data_valid = w_dec_valid;

   always_ff @(posedge clk) begin
      if (sync_reset) begin
         r_hdr_cnt <= '0;
         r_route   <= RT_DROP;
         r_emitted <= 1'b0;
      end else begin
         if (w_sop)                                         r_hdr_cnt <= 4'd1;
         else if (r_state == ST_HEADER && data_in_valid)    r_hdr_cnt <= r_hdr_cnt + 4'd1;
         if (r_state == ST_ROUTE)                           r_route <= w_route_comb;
         r_emitted <= (w_state_next == ST_PAYLOAD) & (r_emitted | w_fwd);
      end
   end

   always_ff @(posedge clk) begin
      if (sync_reset) begin
         r_payload_data    <= '0;
         r_ip_valid        <= 1'b0;
         r_arp_valid       <= 1'b0;
         r_payload_sop     <= 1'b0;
         r_payload_eop     <= 1'b0;
         r_payload_error   <= 1'b0;
         r_payload_abort   <= 1'b0;
         r_frames_accepted <= '0;
         r_frames_dropped  <= '0;
      end else begin
         if (w_fwd) r_payload_data <= data_in;
         r_ip_valid      <= w_fwd & (w_route_eff == RT_IP);
         r_arp_valid     <= w_fwd & (w_route_eff == RT_ARP);
         r_payload_sop   <= w_fwd & ~r_emitted;
         r_payload_eop   <= w_fwd & data_in_eop;
         r_payload_error <= w_fwd & data_in_eop & data_in_error;
         r_payload_abort <= w_abort;
         if (w_inc_acc && r_frames_accepted != CNT_MAX)
            r_frames_accepted <= r_frames_accepted + 1'b1;
         if (w_inc_drop && r_frames_dropped != CNT_MAX)
            r_frames_dropped <= r_frames_dropped + 1'b1;
      end
   end

   assign payload_data    = r_payload_data;
   assign ip_valid        = r_ip_valid;
   assign arp_valid       = r_arp_valid;
   assign payload_sop     = r_payload_sop;
   assign payload_eop     = r_payload_eop;
   assign payload_error   = r_payload_error;
   assign payload_abort   = r_payload_abort;
   assign frames_accepted = r_frames_accepted;
   assign frames_dropped  = r_frames_dropped;

endmodule

// File: tb/tb_eth_rx_dispatch8.sv
// Bench for eth_rx_dispatch8: frame-level reference model plus a stub header
// decoder, per-cycle output comparison and hand-computed phase checkpoints.
module tb_eth_rx_dispatch8;

   logic        clk = 1'b0;
   logic        sync_reset = 1'b1;
   logic [7:0]  data_in = '0;
   logic        data_in_valid = 1'b0;
   logic        data_in_sop = 1'b0;
   logic        data_in_eop = 1'b0;
   logic        data_in_error = 1'b0;
   logic [47:0] local_mac = 48'h02_00_00_00_00_01;
   logic        promisc = 1'b0;
   logic        dec_data_valid;
   logic [47:0] dec_dest_mac = '0;
   logic [15:0] dec_packet_type = '0;
   logic [7:0]  payload_data;
   logic        ip_valid, arp_valid, payload_sop, payload_eop, payload_error, payload_abort;
   logic [15:0] frames_accepted, frames_dropped;

   eth_rx_dispatch8 dut (
      .clk             (clk),
      .sync_reset      (sync_reset),
      .data_in         (data_in),
      .data_in_valid   (data_in_valid),
      .data_in_sop     (data_in_sop),
      .data_in_eop     (data_in_eop),
      .data_in_error   (data_in_error),
      .local_mac       (local_mac),
      .promisc         (promisc),
      .dec_data_valid  (dec_data_valid),
      .dec_dest_mac    (dec_dest_mac),
      .dec_packet_type (dec_packet_type),
      .payload_data    (payload_data),
      .ip_valid        (ip_valid),
      .arp_valid       (arp_valid),
      .payload_sop     (payload_sop),
      .payload_eop     (payload_eop),
      .payload_error   (payload_error),
      .payload_abort   (payload_abort),
      .frames_accepted (frames_accepted),
      .frames_dropped  (frames_dropped)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Stub of the external header decoder: captures dest MAC and EtherType.
   int dec_idx = 0;
   always @(posedge clk) begin
      if (dec_data_valid) begin
         int k;
         k = data_in_sop ? 0 : dec_idx;
         if (k < 6)   dec_dest_mac[47-8*k -: 8] <= data_in;
         if (k == 12) dec_packet_type[15:8] <= data_in;
         if (k == 13) dec_packet_type[7:0]  <= data_in;
         dec_idx = k + 1;
      end
   end

   // Reference model: reasons about whole frames (bytes seen so far), not states.
   logic [7:0] cur[$];
   bit         m_in_frame = 0;
   bit         m_emitted  = 0;
   logic       exp_ip = 0, exp_arp = 0, exp_sop = 0, exp_eop = 0, exp_err = 0, exp_abort = 0;
   logic [7:0] exp_data = '0;
   int         exp_acc = 0, exp_drop = 0;

   function automatic int route_of();
      logic [47:0] dest;
      logic [15:0] etype;
      for (int i = 0; i < 6; i++) dest[47-8*i -: 8] = cur[i];
      etype = {cur[12], cur[13]};
      if (!(dest == local_mac || dest == 48'hFFFF_FFFF_FFFF || promisc)) return 0;
      if (etype == 16'h0800) return 1;
      if (etype == 16'h0806) return 2;
      return 0;
   endfunction

   task automatic m_bump_drop();
      if (exp_drop != 16'hFFFF) exp_drop++;
   endtask

   always @(posedge clk) begin
      exp_ip = 0; exp_arp = 0; exp_sop = 0; exp_eop = 0; exp_err = 0; exp_abort = 0;
      if (sync_reset) begin
         m_in_frame = 0; m_emitted = 0; cur.delete();
         exp_acc = 0; exp_drop = 0; exp_data = '0;
      end else if (data_in_valid) begin
         if (data_in_sop) begin
            if (m_in_frame || data_in_eop) m_bump_drop();
            if (m_in_frame && m_emitted) exp_abort = 1;
            cur.delete();
            cur.push_back(data_in);
            m_in_frame = !data_in_eop;
            m_emitted  = 0;
         end else if (m_in_frame) begin
            int rt;
            cur.push_back(data_in);
            rt = (cur.size() > 14) ? route_of() : 0;
            if (rt != 0) begin
               exp_ip   = (rt == 1);
               exp_arp  = (rt == 2);
               exp_data = data_in;
               exp_sop  = !m_emitted;
               exp_eop  = data_in_eop;
               exp_err  = data_in_eop & data_in_error;
               m_emitted = 1;
            end
            if (data_in_eop) begin
               if (rt != 0) begin
                  if (exp_acc != 16'hFFFF) exp_acc++;
               end else m_bump_drop();
               m_in_frame = 0;
            end
         end
      end
   end

   // Per-cycle comparison against the model, plus event tallies for checkpoints.
   bit cmp_en = 0;
   int n_ip = 0, n_arp = 0, n_abort = 0, n_err = 0, n_dec = 0;
   int last_sop_cyc = 0;
   always @(negedge clk) begin
      if (cmp_en) begin
         logic exp_dec;
         exp_dec = data_in_valid & (data_in_sop | (m_in_frame && cur.size() < 14));
         check("dec_data_valid", dec_data_valid, exp_dec);
         check("ip_valid", ip_valid, exp_ip);
         check("arp_valid", arp_valid, exp_arp);
         check("payload_abort", payload_abort, exp_abort);
         check("frames_accepted", frames_accepted, exp_acc);
         check("frames_dropped", frames_dropped, exp_drop);
         if (exp_ip || exp_arp) begin
            check("payload_data", payload_data, exp_data);
            check("payload_sop", payload_sop, exp_sop);
            check("payload_eop", payload_eop, exp_eop);
            if (exp_eop) check("payload_error", payload_error, exp_err);
         end
      end
      if (ip_valid)  n_ip++;
      if (arp_valid) n_arp++;
      if (payload_abort) n_abort++;
      if (dec_data_valid) n_dec++;
      if ((ip_valid | arp_valid) & payload_eop & payload_error) n_err++;
      if ((ip_valid | arp_valid) & payload_sop) last_sop_cyc = cyc;
   end

   // Stimulus helpers.
   logic [7:0] frame_q[$];
   int pay0_cyc = 0;

   task automatic drive(input logic v, input logic [7:0] d, input logic s, input logic e,
                        input logic er, input logic rst);
      @(posedge clk);
      #1;
      data_in_valid = v; data_in = d; data_in_sop = s; data_in_eop = e;
      data_in_error = er; sync_reset = rst;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic build_frame(input logic [47:0] dest, input logic [15:0] etype,
                              input int plen, input logic [7:0] pstart);
      frame_q.delete();
      for (int i = 0; i < 6; i++) frame_q.push_back(dest[47-8*i -: 8]);
      for (int i = 0; i < 6; i++) frame_q.push_back(8'(8'hA0 + i));
      frame_q.push_back(etype[15:8]);
      frame_q.push_back(etype[7:0]);
      for (int i = 0; i < plen; i++) frame_q.push_back(8'(pstart + 8'(i)));
   endtask

   // Sends the first n bytes (n < 0: all); EOP on the last one if with_eop.
   task automatic send(input int n, input int gap, input bit with_eop, input bit err);
      int last;
      last = (n < 0) ? frame_q.size() - 1 : n - 1;
      for (int i = 0; i <= last; i++) begin
         logic is_eop;
         is_eop = with_eop && (i == last);
         drive(1'b1, frame_q[i], i == 0, is_eop, is_eop & err, 1'b0);
         if (i == 14) pay0_cyc = cyc;
         if (gap > 0 && i < last) idle(gap);
      end
   endtask

   localparam logic [47:0] MAC_ME    = 48'h02_00_00_00_00_01;
   localparam logic [47:0] MAC_OTHER = 48'h02_00_00_00_00_02;
   localparam logic [47:0] MAC_BC    = 48'hFF_FF_FF_FF_FF_FF;

   initial begin
      int b_ip, b_arp, b_abort, b_err, b_dec;
      repeat (3) @(posedge clk);
      #1 sync_reset = 1'b0;
      @(negedge clk);
      cmp_en = 1;
      check("reset ip_valid", ip_valid, 0);
      check("reset arp_valid", arp_valid, 0);
      check("reset payload_data", payload_data, 0);
      check("reset sop/eop/err/abort", {payload_sop, payload_eop, payload_error, payload_abort}, 0);
      check("reset counters", {frames_accepted, frames_dropped}, 0);

      // Unicast IPv4, contiguous payload 0x00..0x13.
      b_ip = n_ip;
      build_frame(MAC_ME, 16'h0800, 20, 8'h00);
      send(-1, 0, 1, 0);
      idle(3);
      check("ipv4 beats", n_ip - b_ip, 20);
      check("ipv4 sop latency", last_sop_cyc - pay0_cyc, 1);
      check("ipv4 accepted", frames_accepted, 1);

      // Broadcast ARP with valid toggling every other cycle.
      b_ip = n_ip; b_arp = n_arp;
      build_frame(MAC_BC, 16'h0806, 28, 8'h40);
      send(-1, 1, 1, 0);
      idle(3);
      check("arp beats", n_arp - b_arp, 28);
      check("arp no ip", n_ip - b_ip, 0);
      check("arp accepted", frames_accepted, 2);

      // Filtering: foreign MAC dropped, then accepted in promiscuous mode.
      b_ip = n_ip;
      build_frame(MAC_OTHER, 16'h0800, 10, 8'h80);
      send(-1, 0, 1, 0);
      idle(3);
      check("filter no payload", n_ip - b_ip, 0);
      check("filter dropped", frames_dropped, 1);
      promisc = 1'b1;
      send(-1, 0, 1, 0);
      idle(3);
      promisc = 1'b0;
      check("promisc beats", n_ip - b_ip, 10);
      check("promisc accepted", frames_accepted, 3);
      build_frame(MAC_ME, 16'h86DD, 10, 8'h90);
      send(-1, 0, 1, 0);
      idle(3);
      check("ipv6 dropped", frames_dropped, 2);

      // Runt: EOP on header byte 10, then a good frame.
      b_dec = n_dec;
      build_frame(MAC_ME, 16'h0800, 6, 8'h10);
      send(10, 0, 1, 0);
      idle(3);
      check("runt dec pulses", n_dec - b_dec, 10);
      check("runt dropped", frames_dropped, 3);
      send(-1, 0, 1, 0);
      idle(3);
      check("post-runt accepted", frames_accepted, 4);

      // SOP after 5 payload bytes, new frame back-to-back.
      b_abort = n_abort; b_ip = n_ip;
      build_frame(MAC_ME, 16'h0800, 12, 8'h20);
      send(19, 0, 0, 0);
      build_frame(MAC_ME, 16'h0800, 8, 8'h60);
      send(-1, 0, 1, 0);
      idle(3);
      check("abort pulses", n_abort - b_abort, 1);
      check("abort dropped", frames_dropped, 4);
      check("abort accepted", frames_accepted, 5);
      check("abort beats", n_ip - b_ip, 13);

      // EOP immediately followed by SOP.
      b_ip = n_ip; b_arp = n_arp;
      build_frame(MAC_ME, 16'h0800, 3, 8'hC0);
      send(-1, 0, 1, 0);
      build_frame(MAC_BC, 16'h0806, 4, 8'hD0);
      send(-1, 0, 1, 0);
      idle(3);
      check("b2b beats", (n_ip - b_ip) + (n_arp - b_arp), 7);
      check("b2b accepted", frames_accepted, 7);

      // EOP with MAC error.
      b_err = n_err;
      build_frame(MAC_ME, 16'h0800, 5, 8'hE0);
      send(-1, 0, 1, 1);
      idle(3);
      check("error eop", n_err - b_err, 1);
      check("error accepted", frames_accepted, 8);

      // Reset after 3 payload bytes; rest of frame must be ignored.
      build_frame(MAC_ME, 16'h0800, 8, 8'h30);
      send(17, 0, 0, 0);
      drive(1'b1, frame_q[17], 1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b1, frame_q[18], 1'b0, 1'b0, 1'b0, 1'b0);
      b_ip = n_ip;
      @(negedge clk);
      check("post-reset ip_valid", ip_valid, 0);
      check("post-reset counters", {frames_accepted, frames_dropped}, 0);
      for (int i = 19; i < frame_q.size(); i++)
         drive(1'b1, frame_q[i], 1'b0, i == frame_q.size() - 1, 1'b0, 1'b0);
      idle(3);
      check("post-reset ignored", n_ip - b_ip, 0);
      check("post-reset eop/abort", n_abort - b_abort, 1);
      send(-1, 0, 1, 0);
      idle(3);
      check("post-reset accepted", frames_accepted, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

endmodule
